// File: rtl/acc_stack_if.sv
// acc_stack_if -- bundles the accumulator's operation, operand and status signals.
//   master : drives IA, SE, mode, push, pop, EA, Din, alu; observes the results
//   slave  : the accumulator; observes the controls and drives Dout, acc_q, zf, nf,
//            cf, full, empty, err
interface acc_stack_if #(
  parameter int WIDTH = 8
);
  logic             IA;
  logic             SE;
  logic [1:0]       mode;
  logic             push;
  logic             pop;
  logic             EA;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] alu;
  logic [WIDTH-1:0] Dout;
  logic [WIDTH-1:0] acc_q;
  logic             zf;
  logic             nf;
  logic             cf;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output IA, SE, mode, push, pop, EA, Din, alu,
    input  Dout, acc_q, zf, nf, cf, full, empty, err
  );

  modport slave (
    input  IA, SE, mode, push, pop, EA, Din, alu,
    output Dout, acc_q, zf, nf, cf, full, empty, err
  );
endinterface

// File: rtl/acc_stack.sv
// acc_stack -- CPU accumulator with load/shift/rotate and a DEPTH-entry save stack.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset (acc, cf, stack count, err)
//   bus      : acc_stack_if.slave
//     IA (active-low op enable), SE (1=Din, 0=alu), mode (00 load, 01 SHL,
//     10 SHR, 11 ROL), push, pop, EA (Dout enable), Din, alu operands;
//     Dout = EA ? acc : 0, acc_q, zf/nf from acc, registered cf,
//     full/empty from the stack count, sticky err on overflow/underflow.
// Edge priority: rst > pop > push > IA op.
module acc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  acc_stack_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] acc;
  logic             cf_r;
  logic [CNT_W-1:0] cnt;
  logic             err_r;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic             is_full;
  logic             is_empty;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic [WIDTH:0]   op_res;

  // Result of the IA operation as {cf, acc}.
  function automatic logic [WIDTH:0] acc_op(
    input logic [1:0]       md,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] src
  );
    logic [WIDTH:0] r;
    case (md)
      2'b00:   r = {1'b0, src};
      2'b01:   r = {cur[WIDTH-1], cur[WIDTH-2:0], 1'b0};
      2'b10:   r = {cur[0], 1'b0, cur[WIDTH-1:1]};
      default: r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
    endcase
    return r;
  endfunction

  assign is_full  = (cnt == CNT_W'(DEPTH));
  assign is_empty = (cnt == '0);
  // Index casts are safe: top_idx is only used when count>0, push_idx only when
  // count<DEPTH, so both values fit in IDX_W bits.
  assign top_idx  = IDX_W'(cnt - CNT_W'(1));
  assign push_idx = IDX_W'(cnt);
  assign op_res   = acc_op(bus.mode, acc, bus.SE ? bus.Din : bus.alu);

  // Control and accumulator state
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cf_r  <= 1'b0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else if (bus.pop) begin
      // A pop (alone or as a swap) overrides the IA op; cf holds.
      if (is_empty) begin
        err_r <= 1'b1;
      end else begin
        acc <= stack_mem[top_idx];
        if (!bus.push) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end else begin
      if (bus.push) begin
        if (is_full) begin
          err_r <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (!bus.IA) begin
        {cf_r, acc} <= op_res;
      end
    end
  end

  // Stack storage: data only, never reset. Writes always take the pre-edge acc.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (bus.push && !bus.pop && !is_full) begin
        stack_mem[push_idx] <= acc;
      end else if (bus.push && bus.pop && !is_empty) begin
        stack_mem[top_idx] <= acc;
      end
    end
  end

  assign bus.acc_q = acc;
  assign bus.Dout  = bus.EA ? acc : '0;
  assign bus.zf    = (acc == '0);
  assign bus.nf    = acc[WIDTH-1];
  assign bus.cf    = cf_r;
  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.err   = err_r;

endmodule
